// File: rtl/store_buffer_pkg.sv
// sb_pkg: shared sizing and entry layout for the store buffer.
//   DEPTH  - number of buffered doubleword stores (power of two, >= 2)
//   ADDR_W - byte-address width
//   DATA_W - doubleword data width
//   PTR_W  - head/tail pointer width
//   sb_entry_t - one buffered store {valid, addr, data}
package sb_pkg;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline-side and memory-side signals of the store buffer.
//   st_*    - store request from MEM stage (valid/addr/data, ready back)
//   ld_*    - load request (valid/addr) and result (data/hit/stall)
//   mem_*   - Data_memory port (write/read/addr/wdata out, rdata in)
//   empty   - no stores pending (fence support)
// Modports: slave = store buffer, master = pipeline + memory model.
interface store_buffer_if;
  import sb_pkg::*;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_hit;
  logic              ld_stall;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
    output st_ready, ld_data, ld_hit, ld_stall,
           mem_write, mem_read, mem_addr, mem_wdata, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
    input  st_ready, ld_data, ld_hit, ld_stall,
           mem_write, mem_read, mem_addr, mem_wdata, empty
  );

endinterface

// File: rtl/store_buffer_match.sv
// sb_match: compares a load address against every buffered store.
//   entries  - buffer contents (invalid entries never match)
//   head     - index of the oldest entry, used for age ordering
//   ld_addr  - load byte address
//   hit      - some valid entry has exactly the load address
//   conflict - some valid entry overlaps the load without matching exactly
//   fwd_data - data of the youngest exactly matching entry
module sb_match #(
  parameter  int DEPTH = sb_pkg::DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_pkg::sb_entry_t [DEPTH-1:0]   entries,
  input  logic [PTR_W-1:0]                head,
  input  logic [sb_pkg::ADDR_W-1:0]       ld_addr,
  output logic                            hit,
  output logic                            conflict,
  output logic [sb_pkg::DATA_W-1:0]       fwd_data
);

  // One extra bit so addr+8 near the top of the address space cannot wrap.
  localparam int AW1 = sb_pkg::ADDR_W + 1;

  logic [DEPTH-1:0] exact_s;
  logic [DEPTH-1:0] overlap_s;
  logic [AW1-1:0]   ld_lo_s;
  logic [AW1-1:0]   ld_hi_s;
  logic [PTR_W-1:0] idx_s;

  assign ld_lo_s = {1'b0, ld_addr};
  assign ld_hi_s = ld_lo_s + AW1'(8);

  // Per-entry exact and doubleword-overlap comparators.
  always_comb begin
    exact_s   = '0;
    overlap_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exact_s[i]   = entries[i].valid && (entries[i].addr == ld_addr);
      overlap_s[i] = entries[i].valid &&
                     (ld_lo_s < ({1'b0, entries[i].addr} + AW1'(8))) &&
                     ({1'b0, entries[i].addr} < ld_hi_s);
    end
  end

  assign hit      = |exact_s;
  assign conflict = |(overlap_s & ~exact_s);

  // Walk oldest to youngest from head; later matches override earlier ones.
  always_comb begin
    fwd_data = '0;
    idx_s    = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s    = head + PTR_W'(i);
      fwd_data = exact_s[idx_s] ? entries[idx_s].data : fwd_data;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: four-entry in-order store buffer in front of Data_memory.
//   clk   - clock, all state on the rising edge
//   reset - synchronous active-high reset, discards pending stores
//   bus   - store_buffer_if.slave: store/load requests, memory port, empty
// Stores are accepted in one cycle and drained one per cycle whenever the
// memory port is not taken by a load that misses the buffer. Loads forward
// from the youngest exact match, stall on partial overlap, else go to memory.
module store_buffer #(
  parameter int DEPTH = sb_pkg::DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_pkg::sb_entry_t [DEPTH-1:0] entries_r;
  logic [PTR_W-1:0]              head_r;
  logic [PTR_W-1:0]              tail_r;
  logic [CNT_W-1:0]              count_r;

  logic                          push_s;
  logic                          drain_s;
  logic                          ld_miss_s;
  logic                          hit_s;
  logic                          conflict_s;
  logic [sb_pkg::DATA_W-1:0]     fwd_data_s;

  // Matching sees only entries held before this edge, so a store pushed in
  // the same cycle is never forwarded.
  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries  (entries_r),
    .head     (head_r),
    .ld_addr  (bus.ld_addr),
    .hit      (hit_s),
    .conflict (conflict_s),
    .fwd_data (fwd_data_s)
  );

  assign bus.st_ready = (count_r != CNT_W'(DEPTH));
  assign bus.empty    = (count_r == CNT_W'(0));

  // Push/drain decisions; a load that misses the buffer owns the memory port.
  always_comb begin
    push_s    = bus.st_valid && (count_r != CNT_W'(DEPTH));
    ld_miss_s = bus.ld_valid && !hit_s && !conflict_s;
    drain_s   = (count_r != CNT_W'(0)) && !ld_miss_s;
  end

  // Load result and memory port drive.
  always_comb begin
    bus.ld_data   = '0;
    bus.ld_hit    = 1'b0;
    bus.ld_stall  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (bus.ld_valid) begin
      if (conflict_s) begin
        bus.ld_stall = 1'b1;
      end else if (hit_s) begin
        bus.ld_hit  = 1'b1;
        bus.ld_data = fwd_data_s;
      end else begin
        bus.mem_read = 1'b1;
        bus.mem_addr = bus.ld_addr;
        bus.ld_data  = bus.mem_rdata;
      end
    end else begin
      bus.ld_data = '0;
    end
    // drain_s is never set together with a missing load, so mem_addr has
    // a single owner.
    if (drain_s) begin
      bus.mem_write = 1'b1;
      bus.mem_addr  = entries_r[head_r].addr;
      bus.mem_wdata = entries_r[head_r].data;
    end else begin
      bus.mem_write = 1'b0;
    end
  end

  // FIFO state: entries, head/tail pointers (wrap modulo DEPTH) and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_r <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
    end else begin
      if (push_s) begin
        entries_r[tail_r] <= '{valid: 1'b1, addr: bus.st_addr, data: bus.st_data};
        tail_r            <= tail_r + PTR_W'(1);
      end
      if (drain_s) begin
        entries_r[head_r].valid <= 1'b0;
        head_r                  <= head_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(drain_s);
    end
  end

endmodule
